// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the serial system bus arbiter.
//   arb_state_e  : arbiter FSM state encodings
//   SEL_W        : width of the master index / mux selects
//   MAX_MASTERS  : upper bound on requesting master ports
//   onehot()     : index -> one-hot mask of MAX_MASTERS bits
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int SEL_W       = 2;
  localparam int MAX_MASTERS = 4;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_SPLIT,
    ARB_SPLIT_BUSY,
    ARB_RESUME
  } arb_state_e;

  function automatic logic [MAX_MASTERS-1:0] onehot(input logic [SEL_W-1:0] idx);
    return MAX_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches the eligible mask upward
// starting one past the previous winner, wrapping at NUM_MASTERS.
// Ports:
//   i_eligible  in   MAX_MASTERS  eligible requesters (bits >= NUM_MASTERS ignored)
//   i_last      in   SEL_W        previous winner
//   o_winner    out  SEL_W        selected index (0 when nothing eligible)
//   o_found     out  1            at least one requester was eligible
// -----------------------------------------------------------------------------
module rr_picker
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [MAX_MASTERS-1:0] i_eligible,
  input  logic [SEL_W-1:0]       i_last,
  output logic [SEL_W-1:0]       o_winner,
  output logic                   o_found
);

  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    o_winner = '0;
    o_found  = 1'b0;
    idx      = 0;
    // Offsets 1..NUM_MASTERS: the previous winner is considered last.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(i_last) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!o_found && i_eligible[SEL_W'(idx)]) begin
        o_found  = 1'b1;
        o_winner = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the serial system bus with split-read support.
// A read whose slave raises ssplit is parked; interim writes from other
// masters may use the forward channel until the parked read resumes.
// Ports:
//   clk     in   1            bus clock
//   rst     in   1            synchronous active-high reset
//   breq    in   NUM_MASTERS  per-master request, held until transaction done
//   bmode   in   NUM_MASTERS  per-master mode: 0 = read, 1 = write
//   ssplit  in   1            OR of slave split lines
//   bgrant  out  NUM_MASTERS  one-hot forward-channel grant (or zero)
//   msel    out  SEL_W        forward-channel owner index (holds when idle)
//   rsel    out  SEL_W        return-channel receiver index
//   msplit  out  NUM_MASTERS  one-hot: this master's read is split/pending
//   bbusy   out  1            any grant active or any split pending
// All outputs are registered.
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic [NUM_MASTERS-1:0] bmode,
  input  logic                   ssplit,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [SEL_W-1:0]       msel,
  output logic [SEL_W-1:0]       rsel,
  output logic [NUM_MASTERS-1:0] msplit,
  output logic                   bbusy
);

  // State and registered outputs
  arb_state_e             r_state;
  logic [NUM_MASTERS-1:0] r_bgrant;
  logic [SEL_W-1:0]       r_msel;
  logic [SEL_W-1:0]       r_rsel;
  logic [NUM_MASTERS-1:0] r_msplit;
  logic                   r_bbusy;
  logic [SEL_W-1:0]       r_split_idx;
  logic                   r_split_done;
  logic [SEL_W-1:0]       r_last;

  // Next-state values
  arb_state_e             w_state;
  logic [NUM_MASTERS-1:0] w_bgrant;
  logic [SEL_W-1:0]       w_msel;
  logic [SEL_W-1:0]       w_rsel;
  logic [NUM_MASTERS-1:0] w_msplit;
  logic                   w_bbusy;
  logic [SEL_W-1:0]       w_split_idx;
  logic                   w_split_done;
  logic [SEL_W-1:0]       w_last;

  // Requests widened to MAX_MASTERS so any SEL_W index is in range.
  logic [MAX_MASTERS-1:0] w_breq;
  logic [MAX_MASTERS-1:0] w_bmode;
  logic [MAX_MASTERS-1:0] w_eligible;
  logic [SEL_W-1:0]       w_pick;
  logic                   w_found;

  assign w_breq  = MAX_MASTERS'(breq);
  assign w_bmode = MAX_MASTERS'(bmode);

  // Only IDLE and SPLIT arbitrate. In SPLIT only writes from masters other
  // than the parked one may win, so the return channel stays free.
  always_comb begin
    w_eligible = '0;
    if (r_state == ARB_IDLE)
      w_eligible = w_breq;
    else if (r_state == ARB_SPLIT)
      w_eligible = w_breq & w_bmode & ~onehot(r_split_idx);
  end

  rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .i_eligible (w_eligible),
    .i_last     (r_last),
    .o_winner   (w_pick),
    .o_found    (w_found)
  );

  always_comb begin
    w_state      = r_state;
    w_bgrant     = r_bgrant;
    w_msel       = r_msel;
    w_msplit     = r_msplit;
    w_split_idx  = r_split_idx;
    w_split_done = r_split_done;
    w_last       = r_last;

    unique case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state  = ARB_BUSY;
          w_bgrant = NUM_MASTERS'(onehot(w_pick));
          w_msel   = w_pick;
          w_last   = w_pick;
        end
      end

      ARB_BUSY: begin
        // A split outranks a simultaneous request drop.
        if (ssplit) begin
          w_state      = ARB_SPLIT;
          w_bgrant     = '0;
          w_split_idx  = r_msel;
          w_msplit     = NUM_MASTERS'(onehot(r_msel));
          w_split_done = 1'b0;
        end else if (!w_breq[r_msel]) begin
          w_state  = ARB_IDLE;
          w_bgrant = '0;
        end
      end

      ARB_SPLIT: begin
        if (!ssplit) begin
          w_state  = ARB_RESUME;
          w_bgrant = NUM_MASTERS'(onehot(r_split_idx));
          w_msel   = r_split_idx;
          w_msplit = '0;
        end else if (w_found) begin
          w_state  = ARB_SPLIT_BUSY;
          w_bgrant = NUM_MASTERS'(onehot(w_pick));
          w_msel   = w_pick;
          w_last   = w_pick;
        end
      end

      ARB_SPLIT_BUSY: begin
        // Remember that the slave came out of split while the interim write
        // still owned the bus; a rising ssplit here cannot come from a write.
        if (!ssplit) w_split_done = 1'b1;
        if (!w_breq[r_msel]) begin
          w_bgrant = '0;
          w_state  = (r_split_done || !ssplit) ? ARB_RESUME : ARB_SPLIT;
        end
      end

      ARB_RESUME: begin
        // Arriving from SPLIT_BUSY the grant is still clear (release gap);
        // re-grant the parked master without moving the round-robin pointer.
        if (r_bgrant == '0) begin
          w_bgrant = NUM_MASTERS'(onehot(r_split_idx));
          w_msel   = r_split_idx;
          w_msplit = '0;
        end else if (!w_breq[r_msel]) begin
          w_state  = ARB_IDLE;
          w_bgrant = '0;
        end
      end

      default: begin
        w_state  = ARB_IDLE;
        w_bgrant = '0;
      end
    endcase

    // The parked master keeps the return channel for the whole split.
    w_rsel  = (w_state inside {ARB_SPLIT, ARB_SPLIT_BUSY, ARB_RESUME}) ? w_split_idx : w_msel;
    w_bbusy = (|w_bgrant) || (|w_msplit);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_bgrant     <= '0;
      r_msel       <= '0;
      r_rsel       <= '0;
      r_msplit     <= '0;
      r_bbusy      <= 1'b0;
      r_split_idx  <= '0;
      r_split_done <= 1'b0;
      r_last       <= SEL_W'(NUM_MASTERS - 1);
    end else begin
      r_state      <= w_state;
      r_bgrant     <= w_bgrant;
      r_msel       <= w_msel;
      r_rsel       <= w_rsel;
      r_msplit     <= w_msplit;
      r_bbusy      <= w_bbusy;
      r_split_idx  <= w_split_idx;
      r_split_done <= w_split_done;
      r_last       <= w_last;
    end
  end

  assign bgrant = r_bgrant;
  assign msel   = r_msel;
  assign rsel   = r_rsel;
  assign msplit = r_msplit;
  assign bbusy  = r_bbusy;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter with NUM_MASTERS = 2. Inputs change 1 ns
// after a rising edge and outputs are checked at that same point, so every
// check sees the registers settled after the edge just taken.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] breq;
  logic [N-1:0] bmode;
  logic         ssplit;
  logic [N-1:0] bgrant;
  logic [1:0]   msel;
  logic [1:0]   rsel;
  logic [N-1:0] msplit;
  logic         bbusy;

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter #(.NUM_MASTERS(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .breq   (breq),
    .bmode  (bmode),
    .ssplit (ssplit),
    .bgrant (bgrant),
    .msel   (msel),
    .rsel   (rsel),
    .msplit (msplit),
    .bbusy  (bbusy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] e_grant,
                         input logic [N-1:0] e_msplit, input logic [1:0] e_msel,
                         input logic [1:0] e_rsel, input logic e_busy);
    chk({tag, ".bgrant"}, 8'(bgrant), 8'(e_grant));
    chk({tag, ".msplit"}, 8'(msplit), 8'(e_msplit));
    chk({tag, ".msel"},   8'(msel),   8'(e_msel));
    chk({tag, ".rsel"},   8'(rsel),   8'(e_rsel));
    chk({tag, ".bbusy"},  8'(bbusy),  8'(e_busy));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with random requests present
    rst    = 1'b1;
    breq   = N'($urandom);
    bmode  = N'($urandom);
    ssplit = 1'b0;
    step();
    step();
    chk_all("reset", 2'b00, 2'b00, 2'd0, 2'd0, 1'b0);
    rst  = 1'b0;
    breq = 2'b00;
    step();
    chk_all("idle", 2'b00, 2'b00, 2'd0, 2'd0, 1'b0);

    // Single grant
    breq  = 2'b01;
    bmode = 2'b00;
    step();
    chk_all("single.grant", 2'b01, 2'b00, 2'd0, 2'd0, 1'b1);
    step(); step(); step(); step();
    chk_all("single.hold", 2'b01, 2'b00, 2'd0, 2'd0, 1'b1);
    breq = 2'b00;
    step();
    chk_all("single.release", 2'b00, 2'b00, 2'd0, 2'd0, 1'b0);

    // Round robin from a fresh pointer: 01, gap, 10, gap, 01
    rst = 1'b1;
    step();
    rst  = 1'b0;
    breq = 2'b11;
    step();
    chk_all("rr.first", 2'b01, 2'b00, 2'd0, 2'd0, 1'b1);
    step(); step(); step();
    chk("rr.first_hold", 8'(bgrant), 8'h01);
    breq = 2'b10;
    step();
    chk_all("rr.gap1", 2'b00, 2'b00, 2'd0, 2'd0, 1'b0);
    breq = 2'b11;
    step();
    chk_all("rr.second", 2'b10, 2'b00, 2'd1, 2'd1, 1'b1);
    step(); step(); step();
    breq = 2'b01;
    step();
    chk_all("rr.gap2", 2'b00, 2'b00, 2'd1, 2'd1, 1'b0);
    breq = 2'b11;
    step();
    chk_all("rr.third", 2'b01, 2'b00, 2'd0, 2'd0, 1'b1);
    breq = 2'b00;
    step();
    step();
    chk("rr.idle", 8'(bgrant), 8'h00);

    // Split parking with an interim write; slave leaves split mid-write
    breq  = 2'b01;
    bmode = 2'b00;
    step();
    chk_all("split.grant", 2'b01, 2'b00, 2'd0, 2'd0, 1'b1);
    ssplit = 1'b1;
    step();
    chk_all("split.park", 2'b00, 2'b01, 2'd0, 2'd0, 1'b1);
    breq  = 2'b11;
    bmode = 2'b00;
    step();
    step();
    chk("split.no_read", 8'(bgrant), 8'h00);
    bmode = 2'b10;
    step();
    chk_all("split.interim", 2'b10, 2'b01, 2'd1, 2'd0, 1'b1);
    ssplit = 1'b0;
    step();
    chk_all("split.done_mid", 2'b10, 2'b01, 2'd1, 2'd0, 1'b1);
    breq = 2'b01;
    step();
    chk_all("split.gap", 2'b00, 2'b01, 2'd1, 2'd0, 1'b1);
    step();
    chk_all("split.resume", 2'b01, 2'b00, 2'd0, 2'd0, 1'b1);
    step();
    chk("split.resume_hold", 8'(bgrant), 8'h01);
    breq = 2'b00;
    step();
    chk_all("split.end", 2'b00, 2'b00, 2'd0, 2'd0, 1'b0);

    // Master 1 parks; interim write ends while still split -> back to SPLIT,
    // then ssplit falls in SPLIT and the re-grant happens at the same edge.
    breq  = 2'b10;
    bmode = 2'b00;
    step();
    chk_all("split2.grant", 2'b10, 2'b00, 2'd1, 2'd1, 1'b1);
    ssplit = 1'b1;
    step();
    chk_all("split2.park", 2'b00, 2'b10, 2'd1, 2'd1, 1'b1);
    breq  = 2'b11;
    bmode = 2'b01;
    step();
    chk_all("split2.interim", 2'b01, 2'b10, 2'd0, 2'd1, 1'b1);
    breq = 2'b10;
    step();
    chk_all("split2.back", 2'b00, 2'b10, 2'd0, 2'd1, 1'b1);
    step();
    chk("split2.wait", 8'(bgrant), 8'h00);
    ssplit = 1'b0;
    step();
    chk_all("split2.resume", 2'b10, 2'b00, 2'd1, 2'd1, 1'b1);
    breq = 2'b00;
    step();
    chk_all("split2.end", 2'b00, 2'b00, 2'd1, 2'd1, 1'b0);

    // Reset in SPLIT_BUSY discards the split
    breq  = 2'b01;
    bmode = 2'b00;
    step();
    chk("rstsplit.grant", 8'(bgrant), 8'h01);
    ssplit = 1'b1;
    step();
    breq  = 2'b11;
    bmode = 2'b10;
    step();
    chk_all("rstsplit.interim", 2'b10, 2'b01, 2'd1, 2'd0, 1'b1);
    rst = 1'b1;
    step();
    chk_all("rstsplit.reset", 2'b00, 2'b00, 2'd0, 2'd0, 1'b0);
    rst    = 1'b0;
    ssplit = 1'b0;
    breq   = 2'b01;
    bmode  = 2'b00;
    step();
    chk_all("rstsplit.regrant", 2'b01, 2'b00, 2'd0, 2'd0, 1'b1);
    breq = 2'b00;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
